// File: rtl/onehot_pkg.sv
// Shared types and helpers for the 128-line one-hot arbiter and encoder.
package onehot_pkg;

    localparam int unsigned N_LINES = 128;
    localparam int unsigned IDX_W   = 7;

    typedef logic [N_LINES-1:0] onehot_t;
    typedef logic [IDX_W-1:0]   idx_t;

    function automatic onehot_t onehot_of(idx_t idx);
        onehot_of = onehot_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: lowest pending index at or above ptr, else lowest pending overall.
module rr_pick
    import onehot_pkg::*;
(
    input  logic [N_LINES-1:0] pending,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic [N_LINES-1:0] onehot,
    output logic               any
);

    logic [N_LINES-1:0] upper_mask;
    logic [N_LINES-1:0] masked;
    logic [N_LINES-1:0] lowest_masked;
    logic [N_LINES-1:0] lowest_all;

    // x & -x isolates the lowest set bit of each search window
    always_comb begin
        upper_mask    = ~(onehot_of(ptr) - N_LINES'(1));
        masked        = pending & upper_mask;
        lowest_masked = masked & (~masked + N_LINES'(1));
        lowest_all    = pending & (~pending + N_LINES'(1));
        any           = |pending;
        onehot        = (|masked) ? lowest_masked : lowest_all;
        idx           = '0;
        for (int unsigned i = 0; i < N_LINES; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Sticky-pending round-robin arbiter producing a registered one-hot grant stream.
// Optional ONEHOT_RR_MERGE_CNT_EN adds a saturating merged-request counter.
module onehot_rr_arbiter
    import onehot_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
`ifdef ONEHOT_RR_MERGE_CNT_EN
    input  logic               merge_clr,
    output logic [15:0]        merge_cnt,
`endif
    input  logic [N_LINES-1:0] req,
    input  logic               out_ready,
    output logic [N_LINES-1:0] dataout,
    output logic               out_valid,
    output logic               pend_empty
);

    logic [N_LINES-1:0] pending;
    logic [N_LINES-1:0] pending_next;
    logic [N_LINES-1:0] clr_mask;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [N_LINES-1:0] pick_onehot;
    logic               pick_any;
    logic               load;

    rr_pick u_pick (
        .pending (pending),
        .ptr     (ptr),
        .idx     (pick_idx),
        .onehot  (pick_onehot),
        .any     (pick_any)
    );

    // Set wins over clear so a re-request during its own grant stays pending
    always_comb begin
        load         = (!out_valid || out_ready) && pick_any;
        clr_mask     = load ? pick_onehot : '0;
        pending_next = (pending & ~clr_mask) | req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= '0;
            dataout    <= '0;
            out_valid  <= 1'b0;
            pend_empty <= 1'b1;
            ptr        <= '0;
        end else begin
            pending    <= pending_next;
            pend_empty <= (pending_next == '0);
            if (load) begin
                dataout   <= pick_onehot;
                out_valid <= 1'b1;
                ptr       <= pick_idx + IDX_W'(1);
            end else if (out_valid && out_ready) begin
                dataout   <= '0;
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ONEHOT_RR_MERGE_CNT_EN
    logic [N_LINES-1:0] merged;
    logic [7:0]         merge_pop;
    logic [16:0]        merge_sum;

    // Requests landing on lines already pending and not being granted this cycle
    always_comb begin
        merged    = req & pending & ~clr_mask;
        merge_pop = '0;
        for (int unsigned i = 0; i < N_LINES; i++) begin
            merge_pop = merge_pop + 8'(merged[i]);
        end
        merge_sum = 17'(merge_cnt) + 17'(merge_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            merge_cnt <= '0;
        end else if (merge_clr) begin
            merge_cnt <= '0;
        end else if (merge_sum[16]) begin
            merge_cnt <= 16'hFFFF;
        end else begin
            merge_cnt <= merge_sum[15:0];
        end
    end
`endif

endmodule
